reg_bank_universal: RTL and testbench
=====================================

REG_BANK_UNIVERSAL -- requirements
Module: reg_bank_universal

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each channel register; SHALL be 2 or more.
REQ-002 Parameter CHANNELS, default 4: number of independent registers; SHALL be 1 or more.
REQ-003 Parameter RESET_VAL, default 0: value (WIDTH bits) loaded into every channel on reset.
REQ-004 Ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on its rising edge.
- reset, in, 1: asynchronous, active-low reset.
- en, in, 1: operation strobe; when low, no state changes.
- ch_sel, in, max(1,clog2(CHANNELS)): target channel.
- mode, in, 3: operation code (REQ-008).
- data_in, in, WIDTH: parallel load value.
- serial_in, in, 1: bit shifted into the target channel.
- data_out, out, WIDTH: combinational view of channel ch_sel.
- all_out, out, CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- serial_out, out, 1: registered bit shifted out by the last shift operation.
- zero, out, CHANNELS: bit k is high when channel k equals 0 (combinational).
- ovf, out, CHANNELS: bit k is the sticky saturation flag of channel k.

Function
REQ-005 Operations SHALL execute only on a rising clk edge with en=1 and reset high, and SHALL affect only channel ch_sel (except CLR_ALL); latency from edge to register and output is 1 cycle.
REQ-006 If ch_sel >= CHANNELS, the operation SHALL be ignored with no state change, and data_out SHALL read 0.
REQ-007 With en=0, every register, serial_out and ovf SHALL hold their values.
REQ-008 Mode encodings:
- 000 HOLD: no change.
- 001 LOAD: reg <= data_in; ovf[ch] <= 0.
- 010 SHL: reg <= {reg[W-2:0], serial_in}; serial_out <= reg[W-1].
- 011 SHR: reg <= {serial_in, reg[W-1:1]}; serial_out <= reg[0].
- 100 INC: reg <= reg+1, saturating at 2^WIDTH-1.
- 101 DEC: reg <= reg-1, saturating at 0.
- 110 CLR: reg <= 0; ovf[ch] <= 0.
- 111 CLR_ALL: every channel <= 0 and all ovf <= 0, regardless of ch_sel.
REQ-009 INC applied at the maximum value and DEC applied at 0 SHALL leave the register unchanged and SHALL set ovf[ch]=1; the arithmetic SHALL never wrap.
REQ-010 ovf[ch] SHALL stay set until LOAD, CLR or CLR_ALL on that channel, or until reset; INC/DEC/SHL/SHR SHALL never clear it.
REQ-011 serial_out SHALL change only on SHL or SHR and SHALL hold its value through all other modes.
REQ-012 data_out, all_out and zero SHALL reflect register state in the same cycle, with no added latency.

Reset
REQ-013 reset=0 SHALL immediately, without waiting for clk, force every channel to RESET_VAL, ovf to 0 and serial_out to 0.
REQ-014 Reset asserted mid-operation SHALL override any concurrent en/mode.
REQ-015 The first operation SHALL take effect on the first rising edge after reset deasserts.

Structure
REQ-016 A shared package SHALL hold the 3-bit mode encodings (HOLD, LOAD, SHL, SHR, INC, DEC, CLR, CLR_ALL) as named constants.
REQ-017 Per-channel logic SHALL be one sub-module, reg_bank_channel (WIDTH, RESET_VAL), instantiated CHANNELS times via generate.
REQ-018 reg_bank_universal SHALL contain only decode, the serial_out register and the output muxes.

Verification (WIDTH=8, CHANNELS=4)
REQ-019 Reset, then LOAD ch2=0xA5 -> all_out=0x00A50000, zero=4'b1011, ovf=0.
REQ-020 On ch1=0xFE, INC three times -> 0xFF after the first, then held; ovf[1]=1 after the second INC; a following LOAD 0x10 clears ovf[1].
REQ-021 On ch0=0x81, SHL with serial_in=0 -> ch0=0x02, serial_out=1; then SHR with serial_in=1 -> ch0=0x81, serial_out=0.
REQ-022 ch3=0, DEC -> ch3 stays 0, ovf[3]=1; then CLR_ALL with ch_sel=0 -> all channels 0, ovf=0.
REQ-023 LOAD 0x55 with en=0, then LOAD with ch_sel out of range (CHANNELS=3 build, ch_sel=3) -> no state change; data_out=0.
REQ-024 Assert reset between clock edges during an INC burst -> outputs reach RESET_VAL before the next edge; the INC is lost.

Source files
------------

// File: rtl/reg_bank_universal_pkg.sv
// Shared definitions for the multi-channel universal register bank:
// operation encodings and channel-select sizing.
package reg_bank_universal_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD    = 3'b000,
    MODE_LOAD    = 3'b001,
    MODE_SHL     = 3'b010,
    MODE_SHR     = 3'b011,
    MODE_INC     = 3'b100,
    MODE_DEC     = 3'b101,
    MODE_CLR     = 3'b110,
    MODE_CLR_ALL = 3'b111
  } mode_e;

  // Select bus is never narrower than one bit, even for a single channel.
  function automatic int sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_channel.sv
// One channel of the register bank: value register, saturating arithmetic,
// shifts and the sticky saturation flag.
module reg_bank_channel
  import reg_bank_universal_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_en,
  input  logic             clr_all,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] value,
  output logic             ovf,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONE = '1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= RESET_VAL;
      ovf   <= 1'b0;
    end else if (clr_all) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (op_en) begin
      case (mode)
        MODE_LOAD: begin
          value <= data_in;
          ovf   <= 1'b0;
        end
        MODE_SHL: value <= {value[WIDTH-2:0], serial_in};
        MODE_SHR: value <= {serial_in, value[WIDTH-1:1]};
        // Saturating arithmetic: a blocked step only raises the sticky flag.
        MODE_INC: begin
          if (value == ALL_ONE) ovf <= 1'b1;
          else                  value <= value + ONE;
        end
        MODE_DEC: begin
          if (value == '0) ovf <= 1'b1;
          else             value <= value - ONE;
        end
        MODE_CLR: begin
          value <= '0;
          ovf   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/reg_bank_universal.sv
// Multi-channel universal register bank: channel decode, the shared
// serial_out register and the read-back muxes.
module reg_bank_universal
  import reg_bank_universal_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CHANNELS  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [sel_width(CHANNELS)-1:0] ch_sel,
  input  logic [2:0]                    mode,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          serial_in,
  output logic [WIDTH-1:0]              data_out,
  output logic [CHANNELS*WIDTH-1:0]     all_out,
  output logic                          serial_out,
  output logic [CHANNELS-1:0]           zero,
  output logic [CHANNELS-1:0]           ovf
);

  localparam int               SEL_W    = sel_width(CHANNELS);
  localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(CHANNELS);

  logic                sel_valid;
  logic                clr_all;
  logic [CHANNELS-1:0] ch_op;
  logic [WIDTH-1:0]    ch_val [CHANNELS];

  // Extra MSB lets the compare work when CHANNELS is a power of two.
  assign sel_valid = ({1'b0, ch_sel} < CH_LIMIT);
  assign clr_all   = en && (mode == MODE_CLR_ALL);

  always_comb begin
    ch_op = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (en && sel_valid && (ch_sel == SEL_W'(k))) ch_op[k] = 1'b1;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    reg_bank_channel #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .op_en     (ch_op[k]),
      .clr_all   (clr_all),
      .mode      (mode),
      .data_in   (data_in),
      .serial_in (serial_in),
      .value     (ch_val[k]),
      .ovf       (ovf[k]),
      .zero      (zero[k])
    );
    assign all_out[k*WIDTH +: WIDTH] = ch_val[k];
  end

  // Out-of-range selects read back as zero.
  always_comb begin
    data_out = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_valid && (ch_sel == SEL_W'(k))) data_out = ch_val[k];
    end
  end

  // The bit leaving the channel comes from its pre-shift value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      serial_out <= 1'b0;
    end else if (en && sel_valid) begin
      if (mode == MODE_SHL)      serial_out <= data_out[WIDTH-1];
      else if (mode == MODE_SHR) serial_out <= data_out[0];
    end
  end

endmodule

// File: tb/tb_reg_bank_universal.sv
// Scoreboard bench for reg_bank_universal: a 4-channel bank with reset value 0
// and a 3-channel bank with reset value 0x3C, sharing the stimulus buses.
module tb_reg_bank_universal;
  import reg_bank_universal_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en_a = 1'b0;
  logic        en_b = 1'b0;
  logic [1:0]  ch_sel = '0;
  logic [2:0]  mode = 3'b000;
  logic [7:0]  data_in = '0;
  logic        serial_in = 1'b0;

  logic [7:0]  data_out_a, data_out_b;
  logic [31:0] all_out_a;
  logic [23:0] all_out_b;
  logic        serial_out_a, serial_out_b;
  logic [3:0]  zero_a, ovf_a;
  logic [2:0]  zero_b, ovf_b;

  always #5 clk = ~clk;

  reg_bank_universal #(.WIDTH(8), .CHANNELS(4), .RESET_VAL(8'h00)) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .ch_sel(ch_sel), .mode(mode),
    .data_in(data_in), .serial_in(serial_in), .data_out(data_out_a),
    .all_out(all_out_a), .serial_out(serial_out_a), .zero(zero_a), .ovf(ovf_a)
  );

  reg_bank_universal #(.WIDTH(8), .CHANNELS(3), .RESET_VAL(8'h3C)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .ch_sel(ch_sel), .mode(mode),
    .data_in(data_in), .serial_in(serial_in), .data_out(data_out_b),
    .all_out(all_out_b), .serial_out(serial_out_b), .zero(zero_b), .ovf(ovf_b)
  );

  typedef enum int {S_ALL, S_ZERO, S_OVF, S_SO, S_DOUT, S_B_ALL, S_B_OVF, S_B_DOUT} sig_e;
  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void push_exp(input string name, input sig_e sig, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.val  = val;
    sb_q.push_back(e);
  endfunction

  // Monitor: outputs are combinational or settle 1 cycle after the edge,
  // so every queued expectation is checked on the following falling edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sig)
        S_ALL:    act = all_out_a;
        S_ZERO:   act = 32'(zero_a);
        S_OVF:    act = 32'(ovf_a);
        S_SO:     act = 32'(serial_out_a);
        S_DOUT:   act = 32'(data_out_a);
        S_B_ALL:  act = 32'(all_out_b);
        S_B_OVF:  act = 32'(ovf_b);
        S_B_DOUT: act = 32'(data_out_b);
        default:  act = 'x;
      endcase
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic op(input logic ea, input logic eb, input logic [1:0] sel,
                    input logic [2:0] md, input logic [7:0] din, input logic sin);
    @(negedge clk);
    #1;
    en_a      = ea;
    en_b      = eb;
    ch_sel    = sel;
    mode      = md;
    data_in   = din;
    serial_in = sin;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, observed while reset is still held.
    #3;
    push_exp("rst_all_a", S_ALL, 32'h0000_0000);
    push_exp("rst_ovf_a", S_OVF, 32'h0);
    push_exp("rst_so_a",  S_SO,  32'h0);
    push_exp("rst_all_b", S_B_ALL, 32'h003C_3C3C);
    push_exp("rst_ovf_b", S_B_OVF, 32'h0);
    @(negedge clk);
    #2 reset = 1'b1;

    // Load into ch2.
    op(1, 0, 2'd2, MODE_LOAD, 8'hA5, 0);
    push_exp("load_all",  S_ALL,  32'h00A5_0000);
    push_exp("load_zero", S_ZERO, 32'b1011);
    push_exp("load_ovf",  S_OVF,  32'h0);
    push_exp("load_dout", S_DOUT, 32'hA5);

    // Saturating increment on ch1.
    op(1, 0, 2'd1, MODE_LOAD, 8'hFE, 0);
    push_exp("ld_fe", S_ALL, 32'h00A5_FE00);
    op(1, 0, 2'd1, MODE_INC, 8'h00, 0);
    push_exp("inc1_all", S_ALL, 32'h00A5_FF00);
    push_exp("inc1_ovf", S_OVF, 32'h0);
    op(1, 0, 2'd1, MODE_INC, 8'h00, 0);
    push_exp("inc2_all", S_ALL, 32'h00A5_FF00);
    push_exp("inc2_ovf", S_OVF, 32'b0010);
    op(1, 0, 2'd1, MODE_INC, 8'h00, 0);
    push_exp("inc3_all", S_ALL, 32'h00A5_FF00);
    push_exp("inc3_ovf", S_OVF, 32'b0010);
    op(1, 0, 2'd1, MODE_LOAD, 8'h10, 0);
    push_exp("reload_all", S_ALL, 32'h00A5_1000);
    push_exp("reload_ovf", S_OVF, 32'h0);

    // Shifts on ch0, serial_out holding through non-shift modes.
    op(1, 0, 2'd0, MODE_LOAD, 8'h81, 0);
    push_exp("ld81_all", S_ALL, 32'h00A5_1081);
    push_exp("ld81_so",  S_SO,  32'h0);
    op(1, 0, 2'd0, MODE_SHL, 8'h00, 0);
    push_exp("shl_all",  S_ALL,  32'h00A5_1002);
    push_exp("shl_so",   S_SO,   32'h1);
    push_exp("shl_dout", S_DOUT, 32'h02);
    op(1, 0, 2'd0, MODE_HOLD, 8'hEE, 1);
    push_exp("hold_all", S_ALL, 32'h00A5_1002);
    push_exp("hold_so",  S_SO,  32'h1);
    op(1, 0, 2'd0, MODE_SHR, 8'h00, 1);
    push_exp("shr_all", S_ALL, 32'h00A5_1081);
    push_exp("shr_so",  S_SO,  32'h0);

    // Decrement floor on ch3, flag kept through a shift, cleared by CLR.
    op(1, 0, 2'd3, MODE_DEC, 8'h00, 0);
    push_exp("dec0_all",  S_ALL,  32'h00A5_1081);
    push_exp("dec0_ovf",  S_OVF,  32'b1000);
    push_exp("dec0_zero", S_ZERO, 32'b1000);
    op(1, 0, 2'd3, MODE_SHL, 8'h00, 1);
    push_exp("shl3_all", S_ALL, 32'h01A5_1081);
    push_exp("shl3_ovf", S_OVF, 32'b1000);
    op(0, 0, 2'd0, MODE_LOAD, 8'h55, 0);
    push_exp("en0_all", S_ALL, 32'h01A5_1081);
    op(1, 0, 2'd3, MODE_CLR, 8'h00, 0);
    push_exp("clr_all3", S_ALL, 32'h00A5_1081);
    push_exp("clr_ovf3", S_OVF, 32'h0);
    op(1, 0, 2'd3, MODE_DEC, 8'h00, 0);
    push_exp("dec0b_ovf", S_OVF, 32'b1000);
    op(1, 0, 2'd0, MODE_CLR_ALL, 8'h00, 0);
    push_exp("clrall_all",  S_ALL,  32'h0);
    push_exp("clrall_ovf",  S_OVF,  32'h0);
    push_exp("clrall_zero", S_ZERO, 32'b1111);

    // Second bank: normal op, disabled op and out-of-range select.
    op(0, 1, 2'd2, MODE_INC, 8'h00, 0);
    push_exp("b_inc_all",  S_B_ALL,  32'h003D_3C3C);
    push_exp("b_inc_dout", S_B_DOUT, 32'h3D);
    op(0, 0, 2'd0, MODE_LOAD, 8'h55, 0);
    push_exp("b_en0_all",  S_B_ALL,  32'h003D_3C3C);
    push_exp("b_en0_dout", S_B_DOUT, 32'h3C);
    op(0, 1, 2'd3, MODE_LOAD, 8'h55, 0);
    push_exp("b_oor_all",  S_B_ALL,  32'h003D_3C3C);
    push_exp("b_oor_dout", S_B_DOUT, 32'h00);
    push_exp("b_oor_ovf",  S_B_OVF,  32'h0);

    // Async reset in the middle of an INC burst on ch1.
    op(1, 0, 2'd0, MODE_LOAD, 8'h80, 0);
    op(1, 0, 2'd0, MODE_SHL, 8'h00, 0);
    push_exp("pre_so", S_SO, 32'h1);
    op(1, 0, 2'd1, MODE_LOAD, 8'hFD, 0);
    op(1, 0, 2'd1, MODE_INC, 8'h00, 0);
    push_exp("burst_all", S_ALL, 32'h0000_FE00);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    push_exp("arst_all",   S_ALL,   32'h0);
    push_exp("arst_so",    S_SO,    32'h0);
    push_exp("arst_all_b", S_B_ALL, 32'h003C_3C3C);
    @(posedge clk);
    #1;
    reset = 1'b1;
    en_a  = 1'b0;
    push_exp("inc_lost", S_ALL, 32'h0);
    op(1, 0, 2'd0, MODE_LOAD, 8'h07, 0);
    push_exp("first_op", S_ALL, 32'h0000_0007);

    en_a = 1'b0;
    en_b = 1'b0;
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
